pipe_arbiter: RTL and testbench

PIPE_ARBITER -- requirements
Module: pipe_arbiter

---
 rtl/pipe_arbiter.sv | 148 ++++++++++++++
 tb/tb_pipe_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_arbiter.sv
// Round-robin arbiter that issues requests into a fixed-latency external datapath.
// Results return through a credit-limited show-ahead FIFO, tagged with the requester id.
module pipe_arbiter #(
  parameter int  NUM_REQ    = 4,
  parameter int  WIDTH      = 8,
  parameter int  LATENCY    = 3,
  parameter int  FIFO_DEPTH = 4,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic [NUM_REQ-1:0]       req_valid_in,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_in,
  output logic [NUM_REQ-1:0]       req_ready_out,
  output logic                     dp_valid_out,
  output logic [WIDTH-1:0]         dp_data_out,
  input  logic [WIDTH-1:0]         dp_data_in,
  output logic                     res_valid_out,
  input  logic                     res_ready_in,
  output logic [WIDTH-1:0]         res_data_out,
  output logic [ID_W-1:0]          res_id_out,
  output logic                     busy_out
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [ID_W-1:0]  LAST_REQ = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]  last_grant;
  logic [CNT_W-1:0] used;
  logic             found;
  logic [ID_W-1:0]  winner;
  logic             issue;
  logic             push;
  logic             pop;

  logic             tag_vld_p [LATENCY];
  logic [ID_W-1:0]  tag_id_p  [LATENCY];

  logic [WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [ID_W-1:0]  fifo_id   [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Issue stage: round-robin search beginning one past the last grant
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid_in[i] &&
            last_grant == ID_W'((i + NUM_REQ - off) % NUM_REQ)) begin
          found  = 1'b1;
          winner = ID_W'(i);
        end
      end
    end
  end

  // A pop this cycle only frees its credit on the following cycle.
  assign issue        = rst_n_in && found && (used < DEPTH_C);
  assign dp_valid_out = issue;

  always_comb begin
    req_ready_out = '0;
    dp_data_out   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (issue && winner == ID_W'(i)) begin
        req_ready_out[i] = 1'b1;
        dp_data_out      = req_data_in[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      last_grant <= LAST_REQ;
    end else if (issue) begin
      last_grant <= winner;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      used <= '0;
    end else if (issue && !pop) begin
      used <= used + CNT_W'(1);
    end else if (!issue && pop) begin
      used <= used - CNT_W'(1);
    end
  end

  // Tag stages: {valid, id} tracks each issue through the datapath latency
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < LATENCY; i++) tag_vld_p[i] <= 1'b0;
    end else begin
      tag_vld_p[0] <= issue;
      for (int i = 1; i < LATENCY; i++) tag_vld_p[i] <= tag_vld_p[i-1];
    end
  end

  always_ff @(posedge clk_in) begin
    tag_id_p[0] <= winner;
    for (int i = 1; i < LATENCY; i++) tag_id_p[i] <= tag_id_p[i-1];
  end

  // Result stage: push on a valid tag tail, show-ahead pop at the head
  assign push = tag_vld_p[LATENCY-1];
  assign pop  = res_valid_out && res_ready_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop) begin
        fifo_cnt <= fifo_cnt + CNT_W'(1);
      end else if (!push && pop) begin
        fifo_cnt <= fifo_cnt - CNT_W'(1);
      end
    end
  end

  // Push-while-full overwrites the head slot exactly as it is popped.
  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_data[wr_ptr] <= dp_data_in;
      fifo_id[wr_ptr]   <= tag_id_p[LATENCY-1];
    end
  end

  assign res_valid_out = (fifo_cnt != '0);
  assign res_data_out  = res_valid_out ? fifo_data[rd_ptr] : '0;
  assign res_id_out    = res_valid_out ? fifo_id[rd_ptr]   : '0;
  assign busy_out      = (used != '0);

endmodule

// File: tb/tb_pipe_arbiter.sv
// Directed bench for pipe_arbiter with an identity 3-stage datapath model.
module tb_pipe_arbiter;

  localparam int NR  = 4;
  localparam int W   = 8;
  localparam int LAT = 3;
  localparam int FD  = 4;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic [NR-1:0] req_valid_in;
  logic [NR*W-1:0] req_data_in;
  logic [NR-1:0] req_ready_out;
  logic          dp_valid_out;
  logic [W-1:0]  dp_data_out;
  logic [W-1:0]  dp_data_in;
  logic          res_valid_out;
  logic          res_ready_in;
  logic [W-1:0]  res_data_out;
  logic [1:0]    res_id_out;
  logic          busy_out;

  int n_total = 0;
  int n_pass  = 0;

  logic [W-1:0] dp_pipe [LAT];

  localparam logic [NR*W-1:0] DATA_DEF = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

  // All-valid, res_ready=1: four issues then one credit-stall cycle, repeating
  logic [3:0] rdy34 [12] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h1,
                             4'h2, 4'h4, 4'h8, 4'h0, 4'h1, 4'h2};
  logic       rv34  [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 1, 1, 1};
  logic [1:0] id34  [12] = '{0, 0, 0, 0, 0, 1, 2, 3, 0, 0, 1, 2};

  // All-valid, res_ready low until cycle 9
  logic [3:0] rdy35 [15] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0,
                             4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
  logic       rv35  [15] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
  logic [1:0] id35  [15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 0, 0};

  pipe_arbiter #(
    .NUM_REQ(NR), .WIDTH(W), .LATENCY(LAT), .FIFO_DEPTH(FD)
  ) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .req_valid_in(req_valid_in),
    .req_data_in(req_data_in),
    .req_ready_out(req_ready_out),
    .dp_valid_out(dp_valid_out),
    .dp_data_out(dp_data_out),
    .dp_data_in(dp_data_in),
    .res_valid_out(res_valid_out),
    .res_ready_in(res_ready_in),
    .res_data_out(res_data_out),
    .res_id_out(res_id_out),
    .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    dp_pipe[0] <= dp_data_out;
    for (int i = 1; i < LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign dp_data_in = dp_pipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk_in);
    #2;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(req_ready_out), 32'h0);
    chk({tag, "_dpv"},   32'(dp_valid_out),  32'h0);
    chk({tag, "_dpd"},   32'(dp_data_out),   32'h0);
    chk({tag, "_resv"},  32'(res_valid_out), 32'h0);
    chk({tag, "_resd"},  32'(res_data_out),  32'h0);
    chk({tag, "_resid"}, 32'(res_id_out),    32'h0);
    chk({tag, "_busy"},  32'(busy_out),      32'h0);
  endtask

  // Holds reset for one edge, then releases it mid-cycle; caller drives cycle 0.
  task automatic do_reset();
    rst_n_in     = 1'b0;
    req_valid_in = '0;
    res_ready_in = 1'b0;
    req_data_in  = DATA_DEF;
    next_cycle();
    rst_n_in = 1'b1;
  endtask

  initial begin
    rst_n_in     = 1'b0;
    req_valid_in = 4'hF;
    req_data_in  = DATA_DEF;
    res_ready_in = 1'b1;
    next_cycle();
    next_cycle();
    #2;
    chk_all_zero("rst");

    // Single request from requester 1
    do_reset();
    req_valid_in = 4'b0010;
    req_data_in  = {8'hA3, 8'hA2, 8'h5A, 8'hA0};
    res_ready_in = 1'b1;
    #2;
    chk("t33_rdy_c0",  32'(req_ready_out), 32'h2);
    chk("t33_dpv_c0",  32'(dp_valid_out),  32'h1);
    chk("t33_dpd_c0",  32'(dp_data_out),   32'h5A);
    chk("t33_busy_c0", 32'(busy_out),      32'h0);
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      req_valid_in = '0;
      #2;
      chk($sformatf("t33_busy_c%0d", c), 32'(busy_out), (c <= 4) ? 32'h1 : 32'h0);
      chk($sformatf("t33_resv_c%0d", c), 32'(res_valid_out), (c == 4) ? 32'h1 : 32'h0);
      if (c == 4) begin
        chk("t33_resid_c4", 32'(res_id_out),   32'h1);
        chk("t33_resd_c4",  32'(res_data_out), 32'h5A);
      end
    end

    // All requesters valid, results drained every cycle
    do_reset();
    for (int c = 0; c < 12; c++) begin
      if (c > 0) next_cycle();
      req_valid_in = 4'hF;
      res_ready_in = 1'b1;
      #2;
      chk($sformatf("t34_rdy_c%0d", c), 32'(req_ready_out), 32'(rdy34[c]));
      chk($sformatf("t34_resv_c%0d", c), 32'(res_valid_out), 32'(rv34[c]));
      if (rv34[c]) begin
        chk($sformatf("t34_resid_c%0d", c), 32'(res_id_out), 32'(id34[c]));
        chk($sformatf("t34_resd_c%0d", c), 32'(res_data_out), 32'h A0 | 32'(id34[c]));
      end
    end

    // All requesters valid, results back-pressured until cycle 9
    do_reset();
    for (int c = 0; c < 15; c++) begin
      if (c > 0) next_cycle();
      req_valid_in = 4'hF;
      res_ready_in = (c >= 9);
      #2;
      chk($sformatf("t35_rdy_c%0d", c), 32'(req_ready_out), 32'(rdy35[c]));
      chk($sformatf("t35_busy_c%0d", c), 32'(busy_out), (c == 0) ? 32'h0 : 32'h1);
      chk($sformatf("t35_resv_c%0d", c), 32'(res_valid_out), 32'(rv35[c]));
      if (rv35[c]) begin
        chk($sformatf("t35_resid_c%0d", c), 32'(res_id_out), 32'(id35[c]));
        chk($sformatf("t35_resd_c%0d", c), 32'(res_data_out), 32'hA0 | 32'(id35[c]));
      end
    end

    // Pointer skip after a grant to requester 3
    do_reset();
    res_ready_in = 1'b1;
    req_valid_in = 4'b1000;
    #2;
    chk("t36_rdy_c0", 32'(req_ready_out), 32'h8);
    next_cycle();
    req_valid_in = 4'b0100;
    #2;
    chk("t36_rdy_c1", 32'(req_ready_out), 32'h4);
    chk("t36_dpd_c1", 32'(dp_data_out),   32'hA2);
    next_cycle();
    req_valid_in = 4'b1100;
    #2;
    chk("t36_rdy_c2", 32'(req_ready_out), 32'h8);
    chk("t36_dpd_c2", 32'(dp_data_out),   32'hA3);

    // Reset in the middle of two in-flight issues
    do_reset();
    res_ready_in = 1'b1;
    req_valid_in = 4'b0001;
    #2;
    chk("t37_rdy_c0", 32'(req_ready_out), 32'h1);
    next_cycle();
    req_valid_in = 4'b0010;
    #2;
    chk("t37_rdy_c1", 32'(req_ready_out), 32'h2);
    next_cycle();
    req_valid_in = 4'hF;
    rst_n_in     = 1'b0;
    #1;
    chk_all_zero("t37_c2");
    for (int c = 3; c <= 6; c++) begin
      next_cycle();
      rst_n_in     = 1'b1;
      req_valid_in = '0;
      #2;
      chk($sformatf("t37_resv_c%0d", c), 32'(res_valid_out), 32'h0);
      chk($sformatf("t37_busy_c%0d", c), 32'(busy_out),      32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
